ov7670_capture: RTL and testbench

Receiving end of the raster-video interface. Samples the OV7670 parallel output (VSYNC, HREF, 8-bit data, RGB565, two bytes per pixel) and aligns to frame and line boundaries. Packs each pixel to the 3-3-2 RGB format used by the VGA output path and emits one frame-buffer write per pixel. Sits between the camera pins and the frame buffer; the frame buffer is read by the 640x480 VGA timing generator.

---
 rtl/ov7670_capture_pkg.sv | 22 ++
 rtl/ov7670_pixel_pack.sv | 56 +++++
 rtl/ov7670_capture.sv | 181 ++++++++++++++++++
 tb/tb_ov7670_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_capture_pkg.sv
// Shared types and helpers for the OV7670 capture path: state encoding,
// default frame geometry and the RGB565 -> RGB332 pixel packing.
package ov7670_capture_pkg;

    localparam int H_PIX_DEF   = 320;
    localparam int V_LINES_DEF = 240;
    localparam int FRAME_PIX   = H_PIX_DEF * V_LINES_DEF;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        ARMED,
        CAPTURE
    } cap_state_e;

    // rg_hi = {R[4:2], G[5:3]} taken from the first byte, b_hi = B[4:3] from the second
    function automatic logic [7:0] rgb565_to_332(input logic [5:0] rg_hi,
                                                 input logic [1:0] b_hi);
        return {rg_hi, b_hi};
    endfunction

endpackage

// File: rtl/ov7670_pixel_pack.sv
// Camera input register stage, byte-phase tracking and RGB332 pixel assembly.
// pix_valid_o is combinational so the top can register the write strobe directly.
module ov7670_pixel_pack
    import ov7670_capture_pkg::*;
(
    input  logic       dclk,
    input  logic       clr,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] d_i,
    input  logic       cap_en_i,
    output logic       vs_o,
    output logic       vs_rise_o,
    output logic       hr_fall_o,
    output logic       pix_valid_o,
    output logic [7:0] pix_o
);

    logic       vs_q;
    logic       vs_prev_q;
    logic       hr_q;
    logic       hr_prev_q;
    logic [7:0] d_q;
    logic       phase_q;
    logic [5:0] b1_q;

    always_ff @(posedge dclk) begin
        if (clr) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            hr_q      <= 1'b0;
            hr_prev_q <= 1'b0;
            d_q       <= 8'd0;
            phase_q   <= 1'b0;
            b1_q      <= 6'd0;
        end else begin
            vs_q      <= vsync_i;
            vs_prev_q <= vs_q;
            hr_q      <= href_i;
            hr_prev_q <= hr_q;
            d_q       <= d_i;
            // Phase is forced to 0 outside an active line, so an odd trailing byte is dropped
            phase_q   <= (cap_en_i && hr_q) ? ~phase_q : 1'b0;
            if (cap_en_i && hr_q && !phase_q) begin
                b1_q <= {d_q[7:5], d_q[2:0]};
            end
        end
    end

    assign vs_o        = vs_q;
    assign vs_rise_o   = vs_q & ~vs_prev_q;
    assign hr_fall_o   = hr_prev_q & ~hr_q;
    assign pix_valid_o = cap_en_i & hr_q & phase_q;
    assign pix_o       = rgb565_to_332(b1_q, d_q[4:3]);

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture top: frame/line alignment FSM, frame-buffer address generation
// and sticky line/frame geometry error flags.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int H_PIX       = H_PIX_DEF,
    parameter int V_LINES     = V_LINES_DEF,
    parameter int ADDR_W      = 17,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        dout,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);

    localparam int NPIX = H_PIX * V_LINES;
    localparam int PW   = $clog2(H_PIX + 1);
    localparam int LW   = $clog2(V_LINES + 1);
    localparam int SW   = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

    localparam logic [PW-1:0]     PIX_FULL  = PW'(H_PIX);
    localparam logic [LW-1:0]     LINE_FULL = LW'(V_LINES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [SW-1:0]     SKIP_LAST = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    cap_state_e        state_q;
    logic [SW-1:0]     skip_q;
    logic [PW-1:0]     pix_cnt_q;
    logic [LW-1:0]     line_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              full_q;
    logic              ovf_q;
    logic              pend_q;
    logic              we_q;
    logic [7:0]        dout_q;
    logic              done_q;
    logic              line_err_q;
    logic              frame_err_q;

    logic       vs_lvl;
    logic       vs_rise;
    logic       hr_fall;
    logic       pix_valid;
    logic [7:0] pix;

    ov7670_pixel_pack u_pack (
        .dclk        (dclk),
        .clr         (clr),
        .vsync_i     (vsync),
        .href_i      (href),
        .d_i         (d),
        .cap_en_i    (state_q == CAPTURE),
        .vs_o        (vs_lvl),
        .vs_rise_o   (vs_rise),
        .hr_fall_o   (hr_fall),
        .pix_valid_o (pix_valid),
        .pix_o       (pix)
    );

    // Counts as they stand once this cycle's pending pixel and line end are folded in
    logic [PW-1:0] pix_cnt_d;
    logic [LW-1:0] line_cnt_d;
    logic          ovf_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        ovf_d      = ovf_q | (pix_valid & full_q);
        if (pend_q && pix_cnt_q != '1) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (hr_fall && line_cnt_q != '1) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q     <= WAIT_SYNC;
            skip_q      <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            addr_q      <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            we_q        <= 1'b0;
            dout_q      <= 8'd0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so the
            // order of statements below never changes what a register sees.
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                WAIT_SYNC: begin
                    if (vs_rise) begin
                        skip_q  <= '0;
                        state_q <= (SKIP_FRAMES == 0) ? ARMED : SKIP;
                    end
                end
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_q == SKIP_LAST) begin
                            state_q <= ARMED;
                        end else begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    addr_q     <= '0;
                    pix_cnt_q  <= '0;
                    line_cnt_q <= '0;
                    full_q     <= 1'b0;
                    ovf_q      <= 1'b0;
                    pend_q     <= 1'b0;
                    if (!vs_lvl) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pend_q <= pix_valid;
                    ovf_q  <= ovf_d;
                    if (pix_valid) begin
                        if (full_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            we_q   <= 1'b1;
                            dout_q <= pix;
                        end
                    end
                    // Address holds at the last location rather than wrapping
                    if (we_q) begin
                        if (addr_q == LAST_ADDR) begin
                            full_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    pix_cnt_q <= pix_cnt_d;
                    if (hr_fall) begin
                        if (pix_cnt_d != PIX_FULL) begin
                            line_err_q <= 1'b1;
                        end
                        line_cnt_q <= line_cnt_d;
                        pix_cnt_q  <= '0;
                    end
                    if (vs_rise) begin
                        if (line_cnt_d == LINE_FULL && !ovf_d) begin
                            done_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ARMED;
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    assign we         = we_q;
    assign addr       = addr_q;
    assign dout       = dout_q;
    assign frame_done = done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 8x4 frame: a pixel table
// drives the byte stream and a scoreboard queue holds every expected write.
module tb_ov7670_capture;

    localparam int H_PIX       = 8;
    localparam int V_LINES     = 4;
    localparam int ADDR_W      = 6;
    localparam int SKIP_FRAMES = 2;
    localparam int NPIX        = H_PIX * V_LINES;

    logic              dclk = 1'b0;
    logic              clr;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    logic              frame_done;
    logic              line_err;
    logic              frame_err;

    always #5 dclk = ~dclk;

    ov7670_capture #(
        .H_PIX       (H_PIX),
        .V_LINES     (V_LINES),
        .ADDR_W      (ADDR_W),
        .SKIP_FRAMES (SKIP_FRAMES)
    ) dut (
        .dclk       (dclk),
        .clr        (clr),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .we         (we),
        .addr       (addr),
        .dout       (dout),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] rgb;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    vec_t tab [8];
    exp_t exp_q [$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int exp_addr = 0;
    int tbl_idx  = 0;
    bit cap      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    // Every write must match the oldest expected entry; a write with none pending is spurious
    always @(negedge dclk) begin
        if (frame_done) done_cnt++;
        if (we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", we, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", addr, mon_e.addr);
                check("wr_dout", dout, mon_e.data);
            end
        end
    end

    task automatic push_expected();
        if (cap && exp_addr < NPIX) begin
            exp_q.push_back('{addr: ADDR_W'(exp_addr), data: tab[tbl_idx].rgb});
            exp_addr++;
        end
    endtask

    task automatic send_line(input int npix, input bit odd, input bit lat);
        href = 1'b1;
        for (int p = 0; p < npix; p++) begin
            d = tab[tbl_idx].hi;
            tick();
            if (lat && p == 1) begin
                check("lat_we_edge2", we, 1'b1);
                check("lat_addr", addr, exp_addr - 1);
            end
            d = tab[tbl_idx].lo;
            push_expected();
            tbl_idx = (tbl_idx + 1) % 8;
            tick();
            if (lat && p == 0) check("lat_we_edge1", we, 1'b0);
        end
        if (odd) begin
            d = 8'hC3;
            tick();
        end
        href = 1'b0;
        d    = 8'h00;
        repeat (3) tick();
    endtask

    task automatic frame(input int nlines, input int short_line, input int odd_line, input bit lat);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == short_line) ? H_PIX - 2 : H_PIX, (l == odd_line), lat && (l == 0));
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic end_frame(input string tag, input bit exp_le, input bit exp_fe);
        vs_pulse();
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_line_err"}, line_err, exp_le);
        check({tag, "_frame_err"}, frame_err, exp_fe);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, we, 1'b0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_line_err"}, line_err, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0] = '{8'hF8, 8'h1F, 8'hE3};
        tab[1] = '{8'h07, 8'hE0, 8'h1C};
        tab[2] = '{8'h00, 8'h00, 8'h00};
        tab[3] = '{8'hFF, 8'hFF, 8'hFF};
        tab[4] = '{8'hA5, 8'h5A, 8'hB7};
        tab[5] = '{8'h5A, 8'hA5, 8'h48};
        tab[6] = '{8'h12, 8'h34, 8'h0A};
        tab[7] = '{8'hE7, 8'h08, 8'hFD};

        clr   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        repeat (3) tick();
        check_all_zero("reset");
        clr = 1'b0;
        tick();

        // Two settling frames produce no writes
        vs_pulse();
        frame(V_LINES, -1, -1, 1'b0);
        vs_pulse();
        frame(V_LINES, -1, -1, 1'b0);
        end_frame("skip", 1'b0, 1'b0);

        cap      = 1'b1;
        exp_addr = 0;
        frame(V_LINES, -1, -1, 1'b0);
        exp_done = 1;
        end_frame("f3", 1'b0, 1'b0);

        // Latency on the first pixel, odd trailing byte on the second line
        exp_addr = 0;
        frame(V_LINES, -1, 1, 1'b1);
        exp_done = 2;
        end_frame("f4", 1'b0, 1'b0);

        // One short line: sticky line error but the frame still completes
        exp_addr = 0;
        frame(V_LINES, 2, -1, 1'b0);
        exp_done = 3;
        end_frame("f5", 1'b1, 1'b0);

        // One line too many: writes stop at the last address, no frame_done
        exp_addr = 0;
        frame(V_LINES + 1, -1, -1, 1'b0);
        check("ovf_addr_hold", addr, NPIX - 1);
        check("ovf_frame_err", frame_err, 1'b1);
        check("line_err_sticky", line_err, 1'b1);
        end_frame("f6", 1'b1, 1'b1);

        // Reset in the middle of a line
        exp_addr = 0;
        send_line(H_PIX, 1'b0, 1'b0);
        href = 1'b1;
        for (int p = 0; p < 3; p++) begin
            d = tab[tbl_idx].hi;
            tick();
            d = tab[tbl_idx].lo;
            push_expected();
            tbl_idx = (tbl_idx + 1) % 8;
            tick();
        end
        d = tab[tbl_idx].hi;
        tick();
        check("pre_clr_we", we, 1'b1);
        check("pre_clr_addr", addr, H_PIX + 2);
        clr = 1'b1;
        tick();
        check_all_zero("mid_clr");
        clr  = 1'b0;
        href = 1'b0;
        d    = 8'h00;
        cap  = 1'b0;
        tick();
        check("clr_pending", exp_q.size(), 0);

        vs_pulse();
        frame(V_LINES, -1, -1, 1'b0);
        vs_pulse();
        frame(V_LINES, -1, -1, 1'b0);
        end_frame("clr_skip", 1'b0, 1'b0);
        cap      = 1'b1;
        exp_addr = 0;
        frame(V_LINES, -1, -1, 1'b0);
        exp_done = 4;
        end_frame("post_clr", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
